prng_uart_tx: RTL and testbench

- Transmit side of the PRNG board link. Takes a 64-bit PRNG word and serializes it onto the UART TX pin as 8 bytes, 8N1 framing.
- A single tx_start pulse launches a frame, typically driven from the PRNG output-flag toggle.
- Sits between the Rule-90 generator and the board TX pin, mirroring the existing UART receive path that loads the key.

---
 rtl/prng_uart_tx.sv | 159 +++++++++++++++
 tb/tb_prng_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prng_uart_tx.sv
// Serializes a NUM_BYTES-wide PRNG word onto a UART TX line as 8N1 bytes.
// Bytes go most-significant first, and the bits within each byte go LSB first.
// A single tx_start pulse in IDLE launches a frame. Stop and start bits run
// back-to-back between bytes, and done pulses once on return to IDLE.
module prng_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int NUM_BYTES    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tx_start,
   input  logic [8*NUM_BYTES-1:0] data_in,
   output logic                   tx_serial,
   output logic                   busy,
   output logic                   done
);

   localparam int DATA_W = 8 * NUM_BYTES;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [IDX_W-1:0]  byte_q, byte_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // The byte on the wire is always the top byte of the shift register.
   // Each finished byte is shifted out to the left.
   logic [7:0] cur_byte;
   logic [2:0] bit_nxt;
   logic       baud_last;

   assign cur_byte  = shift_q[DATA_W-1 -: 8];
   assign bit_nxt   = bit_q + 3'd1;
   assign baud_last = (baud_q == BAUD_LAST);

   // Next-state and next-output logic. The line level is computed one cycle
   // ahead, so every output comes straight from a flop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
               shift_d = data_in;
               byte_d  = '0;
               bit_d   = '0;
               baud_d  = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end

         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = cur_byte[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = cur_byte[bit_nxt];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (byte_q < IDX_LAST) begin
                  byte_d  = byte_q + IDX_W'(1);
                  shift_d = shift_q << 8;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers. An asynchronous reset aborts any frame
   // in flight and does not produce a done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_serial = tx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_prng_uart_tx.sv
// Directed bench for prng_uart_tx. It checks the line, busy and done on every
// cycle of each frame against a bit-position model of the 8N1 frame.
// Three instances are used, with CLKS_PER_BIT set to 4, 2 and 868.
module tb_prng_uart_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] data_in = '0;
   logic        start4 = 1'b0;
   logic        start2 = 1'b0;
   logic        start868 = 1'b0;
   logic        tx4, busy4, done4;
   logic        tx2, busy2, done2;
   logic        tx868, busy868, done868;

   int checks = 0;
   int errors = 0;

   // Clock generator.
   always #5 clk = ~clk;

   prng_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(8)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .tx_start  (start4),
      .data_in   (data_in),
      .tx_serial (tx4),
      .busy      (busy4),
      .done      (done4)
   );

   prng_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(2)) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .tx_start  (start2),
      .data_in   (data_in[15:0]),
      .tx_serial (tx2),
      .busy      (busy2),
      .done      (done2)
   );

   prng_uart_tx #(.CLKS_PER_BIT(868), .NUM_BYTES(1)) u_dut868 (
      .clk       (clk),
      .reset     (reset),
      .tx_start  (start868),
      .data_in   (data_in[7:0]),
      .tx_serial (tx868),
      .busy      (busy868),
      .done      (done868)
   );

   function automatic logic [2:0] obs(input int sel);
      case (sel)
         0:       return {tx4, busy4, done4};
         1:       return {tx2, busy2, done2};
         default: return {tx868, busy868, done868};
      endcase
   endfunction

   // Expected line level at cycle c after the first start-bit fall.
   function automatic logic exp_bit(input logic [63:0] w, input int cpb,
                                    input int nb, input int c);
      int          k;
      int          pos;
      logic [63:0] sh;
      logic [7:0]  b;
      k   = c / (10 * cpb);
      pos = (c % (10 * cpb)) / cpb;
      sh  = w >> (8 * (nb - 1 - k));
      b   = sh[7:0];
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos - 1];
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check3(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed tx/busy/done=%b expected %b", tag, got, exp);
      end
   endtask

   // Walks ncyc cycles of a frame, starting at the cycle where the line has
   // just fallen. If the whole frame is covered, it also checks the done cycle.
   // mode 1: tx_start pulse with all-ones data at cycle 99 (while busy).
   // mode 2: data_in toggles every cycle.
   // mode 3: data_in changes to 1 at cycle 10 (captured by the next frame).
   task automatic run_frame(input int sel, input logic [63:0] w, input int cpb,
                            input int nb, input int mode, input int ncyc,
                            input string tag);
      int total;
      total = nb * 10 * cpb;
      for (int c = 0; c < ncyc; c++) begin
         check3($sformatf("%s c%0d", tag, c), obs(sel), {exp_bit(w, cpb, nb, c), 2'b10});
         if (mode == 1 && c == 99) begin
            start4  = 1'b1;
            data_in = '1;
         end else if (mode == 1 && c == 100) begin
            start4 = 1'b0;
         end
         if (mode == 2) data_in = ~data_in;
         if (mode == 3 && c == 10) data_in = 64'h1;
         cyc();
      end
      if (ncyc == total) begin
         check3({tag, " done"}, obs(sel), 3'b101);
         $display("frame %s word=%h cycles=%0d", tag, w, total);
      end else begin
         $display("partial frame %s word=%h cycles=%0d", tag, w, ncyc);
      end
   endtask

   initial begin
      // Reset state at power-up, asserted between clock edges.
      #1 reset = 1'b0;
      #1;
      check3("reset4", obs(0), 3'b100);
      check3("reset2", obs(1), 3'b100);
      check3("reset868", obs(2), 3'b100);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      check3("idle4", obs(0), 3'b100);

      // Single frame. A tx_start pulse while busy must be ignored.
      data_in = 64'h0123456789ABCDEF;
      start4  = 1'b1;
      check3("t2 pre", obs(0), 3'b100);
      cyc();
      start4 = 1'b0;
      run_frame(0, 64'h0123456789ABCDEF, 4, 8, 1, 320, "t2");
      for (int i = 0; i < 3; i++) begin
         cyc();
         check3($sformatf("t2 post%0d", i), obs(0), 3'b100);
      end

      // tx_start held high: frames run back-to-back, and a third frame
      // launches out of the second done cycle.
      data_in = 64'hA5A5A5A5A5A5A5A5;
      start4  = 1'b1;
      cyc();
      run_frame(0, 64'hA5A5A5A5A5A5A5A5, 4, 8, 3, 320, "t4a");
      cyc();
      run_frame(0, 64'h1, 4, 8, 0, 320, "t4b");
      cyc();
      start4 = 1'b0;

      // Asynchronous reset during byte 3, bit 4 of the third frame.
      run_frame(0, 64'h1, 4, 8, 0, 142, "t5pre");
      #2 reset = 1'b0;
      #1;
      check3("t5 async", obs(0), 3'b100);
      cyc();
      check3("t5 held", obs(0), 3'b100);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check3($sformatf("t5 post%0d", i), obs(0), 3'b100);
      end

      // Clean frame after reset, with data_in toggling every cycle.
      data_in = 64'h1122334455667788;
      start4  = 1'b1;
      cyc();
      start4 = 1'b0;
      run_frame(0, 64'h1122334455667788, 4, 8, 2, 320, "t6");
      cyc();
      check3("t6 post", obs(0), 3'b100);

      // Bit timing with CLKS_PER_BIT = 2.
      data_in = 64'h000000000000C35A;
      start2  = 1'b1;
      check3("cpb2 pre", obs(1), 3'b100);
      cyc();
      start2 = 1'b0;
      run_frame(1, 64'h000000000000C35A, 2, 2, 0, 40, "cpb2");
      cyc();
      check3("cpb2 post", obs(1), 3'b100);

      // Bit timing with CLKS_PER_BIT = 868.
      data_in  = 64'h0000000000000096;
      start868 = 1'b1;
      cyc();
      start868 = 1'b0;
      run_frame(2, 64'h0000000000000096, 868, 1, 0, 8680, "cpb868");
      cyc();
      check3("cpb868 post", obs(2), 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
